// File: rtl/apb_reg_bank_if.sv
// APB3 bus bundle for apb_reg_bank.
//   master : drives p_sel, p_enable, p_write, p_addr, p_w_data, p_strb
//   slave  : drives p_ready, p_slv_err, p_r_data
interface apb_reg_bank_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 32
);
   logic                  p_sel;
   logic                  p_enable;
   logic                  p_write;
   logic [ADDR_W-1:0]     p_addr;
   logic [DATA_W-1:0]     p_w_data;
   logic [DATA_W/8-1:0]   p_strb;
   logic                  p_ready;
   logic                  p_slv_err;
   logic [DATA_W-1:0]     p_r_data;

   modport master (
      output p_sel, p_enable, p_write, p_addr, p_w_data, p_strb,
      input  p_ready, p_slv_err, p_r_data
   );

   modport slave (
      input  p_sel, p_enable, p_write, p_addr, p_w_data, p_strb,
      output p_ready, p_slv_err, p_r_data
   );
endinterface

// File: rtl/apb_reg_bank.sv
// APB3 slave register bank with per-register access modes, byte strobes,
// programmable wait states and slave error on illegal access.
//   p_clk, p_reset : clock and synchronous active-high reset
//   apb            : APB3 slave port (apb_reg_bank_if.slave)
//   hw_status      : RO sources, slice i feeds register i
//   hw_ctrl        : RW/WO register contents, 0 for RO/FIXED slices
//   wr_pulse       : one-cycle pulse per register after a committed write

// One register slot. Mode is fixed at elaboration; only RW/WO slots own flops.
//   commit/wdata/strb : byte-lane write into storage
//   status            : hardware value returned by an RO slot
//   ctrl              : storage out (0 when the slot has no storage)
//   rd_val            : value a legal read returns
//   wr_ok/rd_ok       : which access directions are legal
module apb_reg_slot #(
   parameter int              DATA_W    = 32,
   parameter bit              IS_RO     = 1'b0,
   parameter bit              IS_WO     = 1'b0,
   parameter bit              IS_FIXED  = 1'b0,
   parameter logic [DATA_W-1:0] FIXED_VAL = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                commit,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] strb,
   input  logic [DATA_W-1:0]   status,
   output logic [DATA_W-1:0]   ctrl,
   output logic [DATA_W-1:0]   rd_val,
   output logic                wr_ok,
   output logic                rd_ok
);
   localparam bit HAS_STORE = !IS_RO && !IS_FIXED;

   assign wr_ok = HAS_STORE;
   assign rd_ok = !IS_WO;

   generate
      if (HAS_STORE) begin : g_store
         logic [DATA_W-1:0] store_q;
         logic              unused_status;

         always_ff @(posedge clk) begin
            if (rst) begin
               store_q <= '0;
            end else if (commit) begin
               for (int b = 0; b < DATA_W/8; b++)
                  if (strb[b]) store_q[b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end

         assign ctrl          = store_q;
         assign rd_val        = IS_WO ? '0 : store_q;
         assign unused_status = ^status;
      end else begin : g_const
         logic unused_wr;

         assign ctrl      = '0;
         assign rd_val    = IS_RO ? status : FIXED_VAL;
         assign unused_wr = ^{clk, rst, commit, wdata, strb};
      end
   endgenerate
endmodule

module apb_reg_bank #(
   parameter int                  DATA_W      = 32,
   parameter int                  NUM_REGS    = 6,
   parameter int                  ADDR_W      = 3,
   parameter int                  WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0] RO_MASK     = 6'b000001,
   parameter logic [NUM_REGS-1:0] WO_MASK     = 6'b000010,
   parameter logic [NUM_REGS-1:0] FIXED_MASK  = 6'b001000,
   parameter logic [DATA_W-1:0]   FIXED_VAL   = 32'hCAFE_F00D
) (
   input  logic                         p_clk,
   input  logic                         p_reset,
   apb_reg_bank_if.slave                apb,
   input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
   output logic [NUM_REGS*DATA_W-1:0]   hw_ctrl,
   output logic [NUM_REGS-1:0]          wr_pulse
);
   localparam int STRB_W = DATA_W/8;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] strb;
   } req_t;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

   state_t      state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;
   req_t        req_q, req_d;
   req_t        live, src;
   logic        load;
   logic [DATA_W-1:0] rdata_q;
   logic        err_q;

   logic [NUM_REGS-1:0]             rd_hit, wr_hit, commit, wr_ok_vec, rd_ok_vec;
   logic [NUM_REGS-1:0][DATA_W-1:0] rd_vec, ctrl_vec;
   logic        commit_any;
   logic        hit, wr_ok_s, rd_ok_s, acc_err;
   logic [DATA_W-1:0] rd_mux, rd_next;

   assign live = '{write: apb.p_write, addr: apb.p_addr,
                   wdata: apb.p_w_data, strb: apb.p_strb};

   // In zero-wait mode READY is entered on the setup edge itself, so the read
   // decode must look at the live bus rather than the not-yet-captured request.
   assign src = (state_q == S_IDLE) ? live : req_q;

   assign commit_any = (state_q == S_READY) && apb.p_sel && apb.p_enable &&
                       req_q.write && !err_q;

   genvar i;
   generate
      for (i = 0; i < NUM_REGS; i++) begin : g_slot
         assign rd_hit[i] = (src.addr   == ADDR_W'(i));
         assign wr_hit[i] = (req_q.addr == ADDR_W'(i));
         assign commit[i] = commit_any && wr_hit[i];

         apb_reg_slot #(
            .DATA_W    (DATA_W),
            .IS_RO     (RO_MASK[i]),
            .IS_WO     (WO_MASK[i]),
            .IS_FIXED  (FIXED_MASK[i]),
            .FIXED_VAL (FIXED_VAL)
         ) u_slot (
            .clk    (p_clk),
            .rst    (p_reset),
            .commit (commit[i]),
            .wdata  (req_q.wdata),
            .strb   (req_q.strb),
            .status (hw_status[i*DATA_W +: DATA_W]),
            .ctrl   (ctrl_vec[i]),
            .rd_val (rd_vec[i]),
            .wr_ok  (wr_ok_vec[i]),
            .rd_ok  (rd_ok_vec[i])
         );

         assign hw_ctrl[i*DATA_W +: DATA_W] = ctrl_vec[i];
      end
   endgenerate

   // Response decode; no hit means the index is beyond the implemented range.
   always_comb begin
      rd_mux  = '0;
      hit     = 1'b0;
      wr_ok_s = 1'b0;
      rd_ok_s = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (rd_hit[r]) begin
            rd_mux  = rd_mux | rd_vec[r];
            hit     = 1'b1;
            wr_ok_s = wr_ok_vec[r];
            rd_ok_s = rd_ok_vec[r];
         end
      end
      acc_err = !hit || (src.write ? !wr_ok_s : !rd_ok_s);
      rd_next = (acc_err || src.write) ? '0 : rd_mux;
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      req_d   = req_q;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (apb.p_sel && !apb.p_enable) begin
               req_d = live;
               if (WAIT_STATES == 0) begin
                  state_d = S_READY;
                  load    = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  wcnt_d  = 4'(WAIT_STATES);
               end
            end
         end
         S_WAIT: begin
            if (!apb.p_sel) begin
               state_d = S_IDLE;
            end else if (apb.p_enable) begin
               if (wcnt_q == 4'd1) begin
                  state_d = S_READY;
                  load    = 1'b1;
               end else begin
                  wcnt_d = wcnt_q - 4'd1;
               end
            end
         end
         S_READY: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge p_clk) begin
      if (p_reset) begin
         state_q  <= S_IDLE;
         wcnt_q   <= '0;
         req_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         wr_pulse <= '0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         req_q    <= req_d;
         wr_pulse <= commit;
         if (load) begin
            rdata_q <= rd_next;
            err_q   <= acc_err;
         end
      end
   end

   assign apb.p_ready   = (state_q == S_READY);
   assign apb.p_slv_err = apb.p_ready && err_q;
   assign apb.p_r_data  = apb.p_ready ? rdata_q : '0;
endmodule

// File: tb/tb_apb_reg_bank.sv
module tb_apb_reg_bank;
   localparam int DW = 32, NR = 6, AW = 3, SW = 4, CW = NR*DW;
   localparam logic [NR-1:0] RO = 6'b000001, WO = 6'b000010, FX = 6'b001000;
   localparam logic [DW-1:0] FV = 32'hCAFE_F00D;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic sel, en, wr;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [SW-1:0] strb;
   int            dsel;
   logic [CW-1:0] hw_status;
   logic [CW-1:0] ctrl0, ctrl1;
   logic [NR-1:0] wp0, wp1;

   apb_reg_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
   apb_reg_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

   assign bus0.p_sel = sel && (dsel == 0);
   assign bus1.p_sel = sel && (dsel == 1);
   assign bus0.p_enable = en;   assign bus1.p_enable = en;
   assign bus0.p_write  = wr;   assign bus1.p_write  = wr;
   assign bus0.p_addr   = addr; assign bus1.p_addr   = addr;
   assign bus0.p_w_data = wdata; assign bus1.p_w_data = wdata;
   assign bus0.p_strb   = strb; assign bus1.p_strb   = strb;

   apb_reg_bank #(.WAIT_STATES(0)) u_dut0 (
      .p_clk(clk), .p_reset(rst), .apb(bus0.slave),
      .hw_status(hw_status), .hw_ctrl(ctrl0), .wr_pulse(wp0));
   apb_reg_bank #(.WAIT_STATES(3)) u_dut1 (
      .p_clk(clk), .p_reset(rst), .apb(bus1.slave),
      .hw_status(hw_status), .hw_ctrl(ctrl1), .wr_pulse(wp1));

   // Behavioural model: register contents per DUT plus expected response.
   logic [DW-1:0] mem [2][NR];
   int            ws [2] = '{0, 3};
   logic          exp_ready, exp_err, exp_wr;
   logic [DW-1:0] exp_data;
   logic [NR-1:0] exp_pulse [2];
   bit            chk_en = 1'b0;
   int            n_chk = 0, n_fail = 0;

   task automatic check(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] model_ctrl(input int d);
      logic [CW-1:0] v = '0;
      for (int r = 0; r < NR; r++)
         if (!RO[r] && !FX[r]) v[r*DW +: DW] = mem[d][r];
      return v;
   endfunction

   task automatic model_resp(input int d, input bit w, input int a);
      exp_wr = w;
      if (a >= NR)    begin exp_err = 1'b1; exp_data = '0; end
      else if (RO[a]) begin exp_err = w;    exp_data = w ? '0 : hw_status[a*DW +: DW]; end
      else if (FX[a]) begin exp_err = w;    exp_data = w ? '0 : FV; end
      else if (WO[a]) begin exp_err = !w;   exp_data = '0; end
      else            begin exp_err = 1'b0; exp_data = mem[d][a]; end
   endtask

   task automatic cmp_dut(input int d, input logic rdy, input logic err, input logic [DW-1:0] rd,
                          input logic [NR-1:0] wp, input logic [CW-1:0] ctrl);
      bit act = exp_ready && (dsel == d);
      check($sformatf("dut%0d p_ready", d), rdy, act);
      check($sformatf("dut%0d p_slv_err", d), err, act ? exp_err : 1'b0);
      if (act && !exp_wr) check($sformatf("dut%0d p_r_data", d), rd, exp_data);
      check($sformatf("dut%0d wr_pulse", d), wp, exp_pulse[d]);
      check($sformatf("dut%0d hw_ctrl", d), ctrl, model_ctrl(d));
   endtask

   always @(posedge clk) begin
      exp_pulse[0] = '0;
      exp_pulse[1] = '0;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         cmp_dut(0, bus0.p_ready, bus0.p_slv_err, bus0.p_r_data, wp0, ctrl0);
         cmp_dut(1, bus1.p_ready, bus1.p_slv_err, bus1.p_r_data, wp1, ctrl1);
      end
   end

   function automatic logic dut_ready(input int d);
      return d == 1 ? bus1.p_ready : bus0.p_ready;
   endfunction

   // One APB transfer; abort_at>0 drops p_sel in that access cycle.
   task automatic xfer(input int d, input bit w, input int a, input logic [DW-1:0] wd,
                       input logic [SW-1:0] sb, input int abort_at,
                       output logic [DW-1:0] rd, output logic er, output int lat);
      rd = '0; er = 1'b0; lat = 0;
      dsel = d; sel = 1'b1; en = 1'b0; wr = w; addr = AW'(a); wdata = wd; strb = sb;
      model_resp(d, w, a);
      exp_ready = 1'b0;
      @(posedge clk) #1;
      en = 1'b1;
      for (int n = 1; n <= ws[d] + 1; n++) begin
         if (n == abort_at) begin
            sel = 1'b0; en = 1'b0; exp_ready = 1'b0;
            @(posedge clk) #1;
            return;
         end
         exp_ready = (n == ws[d] + 1);
         @(negedge clk);
         if (dut_ready(d) && lat == 0) lat = n;
         rd = d == 1 ? bus1.p_r_data  : bus0.p_r_data;
         er = d == 1 ? bus1.p_slv_err : bus0.p_slv_err;
         @(posedge clk) #1;
      end
      if (w && !exp_err) begin
         for (int b = 0; b < SW; b++)
            if (sb[b]) mem[d][a][b*8 +: 8] = wd[b*8 +: 8];
         exp_pulse[d] = NR'(1) << a;
      end
      exp_ready = 1'b0;
      sel = 1'b0; en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk) #1;
      for (int d = 0; d < 2; d++) for (int r = 0; r < NR; r++) mem[d][r] = '0;
      exp_ready = 1'b0;
      @(posedge clk) #1;
      rst = 1'b0; sel = 1'b0; en = 1'b0;
   endtask

   task automatic rand_status();
      for (int r = 0; r < NR; r++) hw_status[r*DW +: DW] = $urandom;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] rd, d5;
      logic          er;
      int            lat;
      rst = 1'b1; sel = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0; strb = '0;
      dsel = 0; exp_ready = 1'b0; exp_err = 1'b0; exp_wr = 1'b0; exp_data = '0;
      exp_pulse[0] = '0; exp_pulse[1] = '0;
      for (int d = 0; d < 2; d++) for (int r = 0; r < NR; r++) mem[d][r] = '0;
      rand_status();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      // 1: reset in the middle of a write to reg2 (WAIT_STATES=3 bank)
      dsel = 1; sel = 1'b1; en = 1'b0; wr = 1'b1; addr = 3'd2; wdata = 32'h77; strb = 4'hF;
      exp_ready = 1'b0;
      @(posedge clk) #1; en = 1'b1;
      @(posedge clk) #1;
      do_reset();
      check("rst wr_pulse", wp1, '0);
      check("rst reg2 ctrl", ctrl1[95:64], 32'h0);
      xfer(1, 0, 2, '0, '0, 0, rd, er, lat);
      check("rst reg2 read", rd, 32'h0);

      // 2: RW register
      xfer(0, 1, 2, 32'h0000_0010, 4'hF, 0, rd, er, lat);
      check("rw wr err", er, 1'b0);
      check("rw wr_pulse", wp0, 6'b000100);
      check("rw hw_ctrl", ctrl0[95:64], 32'h10);
      xfer(0, 0, 2, '0, '0, 0, rd, er, lat);
      check("rw rd data", rd, 32'h10);
      check("rw rd err", er, 1'b0);

      // 3: byte strobes
      xfer(0, 1, 4, 32'h1122_3344, 4'hF, 0, rd, er, lat);
      xfer(0, 1, 4, 32'hAABB_CCDD, 4'b0101, 0, rd, er, lat);
      xfer(0, 0, 4, '0, '0, 0, rd, er, lat);
      check("strb rd data", rd, 32'h11BB_33DD);
      xfer(0, 1, 4, 32'hFFFF_FFFF, 4'h0, 0, rd, er, lat);
      check("strb0 wr_pulse", wp0, 6'b010000);
      check("strb0 hw_ctrl", ctrl0[159:128], 32'h11BB_33DD);

      // 4: access modes
      rand_status();
      xfer(0, 1, 0, 32'h1234_5678, 4'hF, 0, rd, er, lat);
      check("ro wr err", er, 1'b1);
      xfer(0, 0, 0, '0, '0, 0, rd, er, lat);
      check("ro rd data", rd, hw_status[31:0]);
      check("ro rd err", er, 1'b0);
      xfer(0, 1, 1, 32'd22, 4'hF, 0, rd, er, lat);
      check("wo wr err", er, 1'b0);
      check("wo hw_ctrl", ctrl0[63:32], 32'd22);
      xfer(0, 0, 1, '0, '0, 0, rd, er, lat);
      check("wo rd err", er, 1'b1);
      check("wo rd data", rd, 32'h0);
      xfer(0, 1, 3, 32'h5555_AAAA, 4'hF, 0, rd, er, lat);
      check("fixed wr err", er, 1'b1);
      xfer(0, 0, 3, '0, '0, 0, rd, er, lat);
      check("fixed rd data", rd, 32'hCAFE_F00D);

      // 5: out-of-range index
      for (int a = 6; a < 8; a++) begin
         xfer(0, 1, a, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
         check($sformatf("oor%0d wr err", a), er, 1'b1);
         check($sformatf("oor%0d wr_pulse", a), wp0, '0);
         xfer(0, 0, a, '0, '0, 0, rd, er, lat);
         check($sformatf("oor%0d rd err", a), er, 1'b1);
         check($sformatf("oor%0d rd data", a), rd, 32'h0);
      end

      // 6: wait states and abort
      xfer(0, 0, 2, '0, '0, 0, rd, er, lat);
      check("ws0 latency", lat, 1);
      d5 = $urandom;
      xfer(1, 1, 5, d5, 4'hF, 0, rd, er, lat);
      check("ws3 wr latency", lat, 4);
      xfer(1, 1, 5, ~d5, 4'hF, 2, rd, er, lat);
      check("abort hw_ctrl", ctrl1[191:160], d5);
      xfer(1, 0, 5, '0, '0, 0, rd, er, lat);
      check("after abort latency", lat, 4);
      check("after abort data", rd, d5);

      // Randomised traffic, back-to-back and with idle gaps.
      for (int it = 0; it < 300; it++) begin
         int d, a, ab;
         bit w;
         d  = int'($urandom_range(0, 1));
         w  = 1'($urandom_range(0, 1));
         a  = int'($urandom_range(0, 7));
         ab = (d == 1 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
         rand_status();
         xfer(d, w, a, $urandom, 4'($urandom_range(0, 15)), ab, rd, er, lat);
         repeat ($urandom_range(0, 2)) @(posedge clk) #1;
      end

      repeat (2) @(posedge clk);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
